instr_encoder_loader: RTL

INSTR_ENCODER_LOADER -- requirements
Module: instr_encoder_loader

---
 rtl/instr_encoder_loader.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/instr_encoder_loader.sv
// Packs instruction field sets into 32-bit words and streams them into
// consecutive instruction-memory slots, one registered write per accept.
module instr_encoder_loader #(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] length,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            operation,
    input  logic                  fmt,
    input  logic                  src_a_reg,
    input  logic [3:0]            src_a,
    input  logic                  src_b_reg,
    input  logic [3:0]            src_b,
    input  logic                  src_c_reg,
    input  logic [3:0]            src_c,
    input  logic [3:0]            dest,
    input  logic [4:0]            shift,
    input  logic                  saturate_disable,
    input  logic                  shift_disable,
    input  logic [11:0]           res_addr,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] instr_count
);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] remaining_q, remaining_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]           wr_data_q, wr_data_d;
    logic                  wr_en_q, wr_en_d;
    logic                  error_q, error_d;

    logic                  accept;
    logic                  last_accept;
    logic                  field_err;
    logic                  wrap_err;
    logic [31:0]           packed_word;

    assign accept      = in_valid && (state_q == LOAD);
    assign last_accept = accept && (remaining_q == ADDR_WIDTH'(1));

    always_comb begin
        packed_word = '0;
        packed_word[15:0] = {src_b_reg, src_b, src_a_reg, src_a, fmt, operation};
        if (fmt) begin
            packed_word[31:16] = {res_addr, dest};
        end else begin
            packed_word[31:16] = {shift_disable, saturate_disable, shift, dest,
                                  src_c_reg, src_c};
        end
    end

    // In fmt=1 the unused fields must be zero and shift_disable mirrors res_addr[11].
    assign field_err = fmt && (src_c_reg || (|src_c) || (|shift) || saturate_disable ||
                               (shift_disable != res_addr[11]));
    // Only a wrap that a later write of this load will land on is an error.
    assign wrap_err  = (addr_q == '1) && (remaining_q != ADDR_WIDTH'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            count_q     <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (length != '0) ? LOAD : DONE;
                end
            end
            LOAD: begin
                if (last_accept) begin
                    state_d = FLUSH;
                end
            end
            FLUSH:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d      = addr_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_en_d     = 1'b0;
        error_d     = error_q;
        if (state_q == IDLE && start) begin
            count_d = '0;
            error_d = 1'b0;
            if (length != '0) begin
                addr_d      = base_addr;
                remaining_d = length;
            end
        end
        if (accept) begin
            wr_en_d     = 1'b1;
            wr_addr_d   = addr_q;
            wr_data_d   = packed_word;
            addr_d      = addr_q + ADDR_WIDTH'(1);
            remaining_d = remaining_q - ADDR_WIDTH'(1);
            count_d     = count_q + ADDR_WIDTH'(1);
            if (field_err || wrap_err) begin
                error_d = 1'b1;
            end
        end
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            FLUSH:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign error       = error_q;
    assign instr_count = count_q;

endmodule
